// File: rtl/gxb_rx_reset_seq.sv
// Reset and CDR-lock sequencer for the 3-channel HDMI RX transceiver: cal wait, analog reset pulse,
// lock-to-ref hold, lock-to-data qualification, then digital reset release. Outputs registered off next state.
module gxb_rx_reset_seq #(
  parameter int NUM_CH    = 3,
  parameter int T_ANALOG  = 40,
  parameter int T_LTR     = 256,
  parameter int T_LTD     = 1000,
  parameter int T_TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [NUM_CH-1:0] rx_cal_busy,
  input  logic [NUM_CH-1:0] rx_is_lockedtoref,
  input  logic [NUM_CH-1:0] rx_is_lockedtodata,
  output logic [NUM_CH-1:0] rx_analogreset,
  output logic [NUM_CH-1:0] rx_digitalreset,
  output logic [NUM_CH-1:0] rx_set_locktoref,
  output logic [NUM_CH-1:0] rx_set_locktodata,
  output logic              rx_ready,
  output logic [2:0]        seq_state,
  output logic [7:0]        retry_count
);

  localparam logic [2:0] S_CAL   = 3'd0;
  localparam logic [2:0] S_ARST  = 3'd1;
  localparam logic [2:0] S_LTR   = 3'd2;
  localparam logic [2:0] S_LTD   = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;

  localparam int T_M1  = (T_ANALOG > T_LTR) ? T_ANALOG : T_LTR;
  localparam int T_M2  = (T_LTD > T_TIMEOUT) ? T_LTD : T_TIMEOUT;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW    = $clog2(T_MAX + 1);
  localparam int TW    = $clog2(T_TIMEOUT + 1);

  localparam logic [CW-1:0] C_ARST_END = CW'(T_ANALOG - 1);
  localparam logic [CW-1:0] C_LTR      = CW'(T_LTR);
  localparam logic [CW-1:0] C_LTD      = CW'(T_LTD);
  localparam logic [TW-1:0] C_TMO      = TW'(T_TIMEOUT);

  logic [NUM_CH-1:0] r_cal_s1, r_cal_s2;
  logic [NUM_CH-1:0] r_ltr_s1, r_ltr_s2;
  logic [NUM_CH-1:0] r_ltd_s1, r_ltd_s2;
  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_tmo;
  logic [7:0]        r_retry;
  logic              r_arst, r_drst, r_ltref, r_ready;

  logic              w_any_cal, w_all_ltr, w_all_ltd, w_retry_inc;
  logic [2:0]        w_nxt;
  logic [CW-1:0]     w_cnt_p1, w_cnt_nxt;
  logic [TW-1:0]     w_tmo_p1, w_tmo_nxt;

  // Cal-busy synchronizer resets to busy so nothing proceeds before real status is sampled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cal_s1 <= '1;
      r_cal_s2 <= '1;
      r_ltr_s1 <= '0;
      r_ltr_s2 <= '0;
      r_ltd_s1 <= '0;
      r_ltd_s2 <= '0;
    end else begin
      r_cal_s1 <= rx_cal_busy;
      r_cal_s2 <= r_cal_s1;
      r_ltr_s1 <= rx_is_lockedtoref;
      r_ltr_s2 <= r_ltr_s1;
      r_ltd_s1 <= rx_is_lockedtodata;
      r_ltd_s2 <= r_ltd_s1;
    end
  end

  assign w_any_cal = |r_cal_s2;
  assign w_all_ltr = &r_ltr_s2;
  assign w_all_ltd = &r_ltd_s2;
  assign w_cnt_p1  = r_cnt + CW'(1);
  assign w_tmo_p1  = r_tmo + TW'(1);

  always_comb begin
    w_nxt       = r_state;
    w_retry_inc = 1'b0;
    case (r_state)
      S_CAL:   if (!w_any_cal) w_nxt = S_ARST;
      S_ARST:  if (r_cnt == C_ARST_END) w_nxt = S_LTR;
      S_LTR: begin
        if (w_all_ltr && (w_cnt_p1 == C_LTR)) begin
          w_nxt = S_LTD;
        end else if (w_tmo_p1 == C_TMO) begin
          w_nxt       = S_ARST;
          w_retry_inc = 1'b1;
        end
      end
      S_LTD: begin
        if (w_all_ltd && (w_cnt_p1 == C_LTD)) begin
          w_nxt = S_READY;
        end else if (w_tmo_p1 == C_TMO) begin
          w_nxt       = S_ARST;
          w_retry_inc = 1'b1;
        end
      end
      S_READY: begin
        if (!w_all_ltd) begin
          w_nxt       = S_ARST;
          w_retry_inc = 1'b1;
        end
      end
      default: w_nxt = S_CAL;
    endcase
    if (restart || w_any_cal) begin
      w_nxt       = S_CAL;
      w_retry_inc = 1'b0;
    end
  end

  // Both counters restart from zero whenever the state changes
  always_comb begin
    w_cnt_nxt = '0;
    w_tmo_nxt = '0;
    if (w_nxt == r_state) begin
      case (r_state)
        S_ARST: w_cnt_nxt = w_cnt_p1;
        S_LTR: begin
          w_cnt_nxt = w_all_ltr ? w_cnt_p1 : '0;
          w_tmo_nxt = w_tmo_p1;
        end
        S_LTD: begin
          w_cnt_nxt = w_all_ltd ? w_cnt_p1 : '0;
          w_tmo_nxt = w_tmo_p1;
        end
        default: begin
          w_cnt_nxt = '0;
          w_tmo_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CAL;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_retry <= '0;
      r_arst  <= 1'b1;
      r_drst  <= 1'b1;
      r_ltref <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_retry_inc && (r_retry != 8'hFF)) r_retry <= r_retry + 8'd1;
      r_arst  <= (w_nxt == S_CAL) || (w_nxt == S_ARST);
      r_drst  <= (w_nxt != S_READY);
      r_ltref <= (w_nxt == S_CAL) || (w_nxt == S_ARST) || (w_nxt == S_LTR);
      r_ready <= (w_nxt == S_READY);
    end
  end

  assign rx_analogreset    = {NUM_CH{r_arst}};
  assign rx_digitalreset   = {NUM_CH{r_drst}};
  assign rx_set_locktoref  = {NUM_CH{r_ltref}};
  assign rx_set_locktodata = '0;
  assign rx_ready          = r_ready;
  assign seq_state         = r_state;
  assign retry_count       = r_retry;

endmodule

// File: doc/gxb_rx_reset_seq.md
# gxb_rx_reset_seq

Reset and CDR-lock sequencer for the 3-channel HDMI receive transceiver. It waits for calibration, pulses analog reset, holds the CDR in lock-to-reference until stable, then releases it to automatic lock-to-data. It removes digital reset only after data lock has been stable. It sits between the HDMI RX top level and the transceiver's per-channel reset/lock ports, and re-runs the sequence on loss of lock, recalibration or an explicit restart.

## Interface
Parameters:
- NUM_CH, 3, transceiver channels (all sequenced together)
- T_ANALOG, 40, cycles analog reset is held asserted
- T_LTR, 256, cycles all lockedtoref must be continuously high before releasing to data
- T_LTD, 1000, cycles all lockedtodata must be continuously high before releasing digital reset
- T_TIMEOUT, 100000, max cycles in S_LTR or S_LTD before retry

Ports:
- clk  in  1  sequencer clock (same domain as reconfig_clk)
- reset  in  1  asynchronous, active-high
- restart  in  1  single-cycle request to rerun the full sequence
- rx_cal_busy  in  NUM_CH  per-channel calibration busy (async)
- rx_is_lockedtoref  in  NUM_CH  CDR ref-lock status (async)
- rx_is_lockedtodata  in  NUM_CH  CDR data-lock status (async)
- rx_analogreset  out  NUM_CH  analog reset, all bits identical
- rx_digitalreset  out  NUM_CH  digital reset, all bits identical
- rx_set_locktoref  out  NUM_CH  force CDR lock-to-reference
- rx_set_locktodata  out  NUM_CH  force CDR lock-to-data; always 0 (automatic mode)
- rx_ready  out  1  link receive path usable
- seq_state  out  3  current state encoding
- retry_count  out  8  saturating count of timeout/lock-loss retries

## Operation
- All async status inputs pass through 2-flop synchronizers. The conditions below use the synchronized values, ANDed across channels ("all") or ORed ("any").
- States and encodings: S_CAL=0, S_ARST=1, S_LTR=2, S_LTD=3, S_READY=4.
- S_CAL: analog=1, digital=1, locktoref=1, ready=0. Go to S_ARST when no cal_busy is high. Counter loads 0.
- S_ARST: analog=1, digital=1, locktoref=1. Count T_ANALOG cycles, then go to S_LTR.
- S_LTR: analog=0, digital=1, locktoref=1.
  - Stability counter increments while all lockedtoref are high and clears to 0 when any is low.
  - Reaching T_LTR goes to S_LTD.
  - Timeout counter reaching T_TIMEOUT goes to S_ARST and increments retry_count.
- S_LTD: analog=0, digital=1, locktoref=0.
  - Same stability/timeout scheme on all lockedtodata, using T_LTD.
  - Success goes to S_READY.
  - Timeout goes to S_ARST with retry++.
- S_READY: analog=0, digital=0, locktoref=0, ready=1.
  - Any lockedtodata low goes to S_ARST with retry++.
- Priority, highest first, from any state:
  1. reset
  2. restart → S_CAL
  3. any cal_busy → S_CAL (no retry increment)
  4. per-state rules above
- retry_count saturates at 255 and clears only on reset.
- Counters are a single shared counter sized to hold max(T_ANALOG, T_LTR, T_LTD, T_TIMEOUT), plus a separate timeout counter. Both clear on every state change.

## Timing
- Reset values:
  - state S_CAL (seq_state=0)
  - rx_analogreset, rx_digitalreset, rx_set_locktoref = all ones
  - rx_set_locktodata = 0, rx_ready = 0, retry_count = 0, counters = 0
- All outputs are registered and decoded from the state register. They change in the same cycle seq_state changes.
- Synchronizer latency is 2 cycles, so input edge to state change takes 3 clk edges.
- S_ARST dwell is exactly T_ANALOG cycles.
- The S_LTR exit fires on the cycle the stability count equals T_LTR (T_LTR consecutive high samples).
- Simultaneous stability-complete and timeout in the same cycle: stability wins.
- A restart or cal_busy arriving while already in S_CAL has no further effect, apart from holding S_CAL while cal_busy is high.
- Async reset mid-sequence forces the reset values immediately, without waiting for a clock edge.

## Test plan
Use T_ANALOG=4, T_LTR=8, T_LTD=16, T_TIMEOUT=64.
- **Nominal bring-up:** cal_busy=0, lockedtoref=111 and lockedtodata=111 constant.
  - Required: S_CAL→S_ARST→S_LTR→S_LTD→S_READY.
  - Analog reset low after 4 cycles in S_ARST; locktoref low on S_LTD entry; digital reset low and rx_ready=1 on the 16th stable cycle.
  - retry_count=0.
- **Glitchy ref lock:** drop lockedtoref[1] for 1 cycle at stability count 5.
  - Required: count restarts at 0; S_LTD is entered 8 cycles after the glitch is seen.
- **LTD timeout:** lockedtodata=011 held.
  - Required: S_ARST after 64 cycles in S_LTD; retry_count=1; sequence repeats.
  - After 300 repeats retry_count=255.
- **Lock loss in S_READY:** lockedtodata[2]→0.
  - Required: 3 edges later S_ARST; rx_ready=0 and analog and digital reset =111; retry_count increments.
- **Recalibration/restart:** pulse restart in S_READY while cal_busy[0]=1 for 10 cycles.
  - Required: S_CAL, held until cal_busy clears, then full sequence; retry_count unchanged.
- **Async reset mid-S_LTD:** assert reset between clock edges.
  - Required: outputs return to reset values immediately; seq_state=0.
